// File: rtl/etapa_ex.sv
// ---------------------------------------------------------------------------
// etapa_ex -- execute stage sitting right after the ID/EX buffer.
//
// Computes the ALU result and the branch target (PC+4 + imm<<2) and registers
// them, together with the store data, destination register and the
// write-back/memory controls, into the EX/MEM outputs.
//
// Optional feature, macro EX_MULT_EN:
//   defined   -> ALUOp=10 runs an iterative shift-add multiplier (MUL_CYC
//                steps). The front end is stalled through stall_out until
//                the final step.
//   undefined -> no multiplier. ALUOp=10 yields result 0 with 1-cycle
//                latency, and stall_out is tied to 0.
//
// Ports:
//   clk, rst (sync, active-high), flush (kills the in-flight instruction)
//   in_valid, AdderIn, DatoLec1, DatoLec2, SignExtend, Instr_rt, Instr_rd,
//   ALUSrc, RegDst, ALUOp[3:0], RegWrite_in, MemRead_in, MemWrite_in  (ID/EX)
//   stall_out                                           (to the front end)
//   ResultOut, DatoEscOut, BranchOut, ZeroOut, RegDestOut, RegWriteOut,
//   MemReadOut, MemWriteOut, ValidOut                   (EX/MEM)
// ---------------------------------------------------------------------------
module etapa_ex #(
  parameter int W       = 32,
  parameter int MUL_CYC = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] AdderIn,
  input  logic [W-1:0] DatoLec1,
  input  logic [W-1:0] DatoLec2,
  input  logic [W-1:0] SignExtend,
  input  logic [4:0]   Instr_rt,
  input  logic [4:0]   Instr_rd,
  input  logic         ALUSrc,
  input  logic         RegDst,
  input  logic [3:0]   ALUOp,
  input  logic         RegWrite_in,
  input  logic         MemRead_in,
  input  logic         MemWrite_in,
  output logic         stall_out,
  output logic [W-1:0] ResultOut,
  output logic [W-1:0] DatoEscOut,
  output logic [W-1:0] BranchOut,
  output logic         ZeroOut,
  output logic [4:0]   RegDestOut,
  output logic         RegWriteOut,
  output logic         MemReadOut,
  output logic         MemWriteOut,
  output logic         ValidOut
);

  function automatic logic [W-1:0] alu_f(input logic [3:0]   op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [4:0]   sh);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return (sa < sb) ? W'(1) : '0;
      4'd7:    return b << sh;
      4'd8:    return b >> sh;
      4'd9:    return {b[15:0], {(W-16){1'b0}}};
      default: return '0;
    endcase
  endfunction

  logic [W-1:0] op_b;
  logic [W-1:0] alu_res;
  logic [W-1:0] branch;
  logic [4:0]   dest;
  logic         issue;

  assign op_b    = ALUSrc ? SignExtend : DatoLec2;
  assign alu_res = alu_f(ALUOp, DatoLec1, op_b, SignExtend[10:6]);
  assign branch  = AdderIn + (SignExtend << 2);
  assign dest    = RegDst ? Instr_rd : Instr_rt;

`ifdef EX_MULT_EN
  localparam int CW = $clog2(MUL_CYC);

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [W-1:0]  mcand, mplier, acc, acc_step;
  logic [W-1:0]  m_dato, m_branch;
  logic [4:0]    m_dest;
  logic          m_rw, m_mr, m_mw;
  logic          mul_start, mul_done;

  assign issue = (state == IDLE) && in_valid && (ALUOp != 4'd10);

  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    acc_step  = acc + (mplier[0] ? mcand : '0);
    case (state)
      IDLE: begin
        if (in_valid && ALUOp == 4'd10) begin
          stall_out = 1'b1;
          if (!flush) begin
            mul_start = 1'b1;
            state_nxt = MUL;
          end
        end
      end
      MUL: begin
        // Stall drops on the last step so ID/EX advances on the same edge
        // that writes the product.
        stall_out = (cnt != CW'(MUL_CYC - 1));
        if (cnt == CW'(MUL_CYC - 1)) begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Multiplier stage: operands/controls latched at start, then one shift-add per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      m_dato   <= '0;
      m_branch <= '0;
      m_dest   <= '0;
      m_rw     <= 1'b0;
      m_mr     <= 1'b0;
      m_mw     <= 1'b0;
    end else if (mul_start) begin
      cnt      <= '0;
      mcand    <= DatoLec1;
      mplier   <= op_b;
      acc      <= '0;
      m_dato   <= DatoLec2;
      m_branch <= branch;
      m_dest   <= dest;
      m_rw     <= RegWrite_in;
      m_mr     <= MemRead_in;
      m_mw     <= MemWrite_in;
    end else if (state == MUL) begin
      cnt    <= cnt + 1'b1;
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign issue     = in_valid;
  assign stall_out = 1'b0;
`endif

  // EX/MEM register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      ResultOut   <= '0;
      DatoEscOut  <= '0;
      BranchOut   <= '0;
      ZeroOut     <= 1'b0;
      RegDestOut  <= '0;
      RegWriteOut <= 1'b0;
      MemReadOut  <= 1'b0;
      MemWriteOut <= 1'b0;
      ValidOut    <= 1'b0;
    end else if (flush) begin
      RegWriteOut <= 1'b0;
      MemReadOut  <= 1'b0;
      MemWriteOut <= 1'b0;
      ValidOut    <= 1'b0;
`ifdef EX_MULT_EN
    end else if (mul_done) begin
      ResultOut   <= acc_step;
      ZeroOut     <= (acc_step == '0);
      DatoEscOut  <= m_dato;
      BranchOut   <= m_branch;
      RegDestOut  <= m_dest;
      RegWriteOut <= m_rw;
      MemReadOut  <= m_mr;
      MemWriteOut <= m_mw;
      ValidOut    <= 1'b1;
`endif
    end else if (issue) begin
      ResultOut   <= alu_res;
      ZeroOut     <= (alu_res == '0);
      DatoEscOut  <= DatoLec2;
      BranchOut   <= branch;
      RegDestOut  <= dest;
      RegWriteOut <= RegWrite_in;
      MemReadOut  <= MemRead_in;
      MemWriteOut <= MemWrite_in;
      ValidOut    <= 1'b1;
    end else begin
      // Bubble (or multiply still running): data holds, controls cleared.
      RegWriteOut <= 1'b0;
      MemReadOut  <= 1'b0;
      MemWriteOut <= 1'b0;
      ValidOut    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_etapa_ex.sv
module tb_etapa_ex;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [31:0] AdderIn, DatoLec1, DatoLec2, SignExtend;
  logic [4:0]  Instr_rt, Instr_rd;
  logic        ALUSrc, RegDst;
  logic [3:0]  ALUOp;
  logic        RegWrite_in, MemRead_in, MemWrite_in;
  logic        stall_out;
  logic [31:0] ResultOut, DatoEscOut, BranchOut;
  logic        ZeroOut;
  logic [4:0]  RegDestOut;
  logic        RegWriteOut, MemReadOut, MemWriteOut, ValidOut;

  etapa_ex #(.W(32), .MUL_CYC(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .AdderIn(AdderIn), .DatoLec1(DatoLec1), .DatoLec2(DatoLec2),
    .SignExtend(SignExtend), .Instr_rt(Instr_rt), .Instr_rd(Instr_rd),
    .ALUSrc(ALUSrc), .RegDst(RegDst), .ALUOp(ALUOp),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .stall_out(stall_out), .ResultOut(ResultOut), .DatoEscOut(DatoEscOut),
    .BranchOut(BranchOut), .ZeroOut(ZeroOut), .RegDestOut(RegDestOut),
    .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
    .ValidOut(ValidOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] dato;
    logic [31:0] br;
    logic [4:0]  dst;
    logic        z;
    logic [2:0]  ctl;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample and score any result the DUT produced.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (ValidOut === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'd0, ValidOut}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", ResultOut, e.res);
        chk("zero", {31'd0, ZeroOut}, {31'd0, e.z});
        chk("dest", {27'd0, RegDestOut}, {27'd0, e.dst});
        chk("branch", BranchOut, e.br);
        chk("store_data", DatoEscOut, e.dato);
        chk("controls", {29'd0, RegWriteOut, MemReadOut, MemWriteOut}, {29'd0, e.ctl});
        last_res = e.res;
      end
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] se, input logic alusrc, input logic regdst,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pc,
                       input logic [2:0] ctl);
    ALUOp = op; DatoLec1 = a; DatoLec2 = b; SignExtend = se;
    ALUSrc = alusrc; RegDst = regdst; Instr_rt = rt; Instr_rd = rd; AdderIn = pc;
    {RegWrite_in, MemRead_in, MemWrite_in} = ctl;
    in_valid = 1'b1;
  endtask

  // Expected entry derived from the currently driven inputs and a hand-computed result.
  task automatic push_exp(input logic [31:0] res);
    exp_t e;
    e.res  = res;
    e.dato = DatoLec2;
    e.br   = AdderIn + (SignExtend << 2);
    e.dst  = RegDst ? Instr_rd : Instr_rt;
    e.z    = (res == 32'd0);
    e.ctl  = {RegWrite_in, MemRead_in, MemWrite_in};
    sb.push_back(e);
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] se, input logic alusrc,
                       input logic regdst, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [2:0] ctl, input logic [31:0] res);
    drive(op, a, b, se, alusrc, regdst, rt, rd, pc, ctl);
    push_exp(res);
    tick();
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0;
    drive(4'd0, 32'h11, 32'h22, 32'h33, 1'b0, 1'b1, 5'd1, 5'd2, 32'h44, 3'b111);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_result", ResultOut, 32'd0);
    chk("rst_dato", DatoEscOut, 32'd0);
    chk("rst_branch", BranchOut, 32'd0);
    chk("rst_flags", {25'd0, ZeroOut, RegWriteOut, MemReadOut, MemWriteOut, ValidOut, stall_out, 1'b0},
        32'd0);
    chk("rst_dest", {27'd0, RegDestOut}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;

    issue("add",   4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd9, 5'd3, 32'd0, 3'b100, 32'd12);
    issue("sub",   4'd1, 32'd9, 32'd9, 32'd4, 1'b0, 1'b0, 5'd2, 5'd7, 32'h100, 3'b100, 32'd0);
    chk("sub_branch", BranchOut, 32'h110);
    chk("sub_zero", {31'd0, ZeroOut}, 32'd1);
    issue("slt",   4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd4, 32'h8, 3'b100, 32'd1);
    issue("addw",  4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd5, 32'hC, 3'b100, 32'd0);
    issue("and",   4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 1'b0, 1'b1, 5'd0, 5'd6, 32'h10, 3'b100,
          32'h00F0_000F);
    issue("or",    4'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 1'b0, 1'b1, 5'd0, 5'd6, 32'h14, 3'b100,
          32'hFFF0_0FFF);
    issue("xor",   4'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 1'b0, 1'b1, 5'd0, 5'd6, 32'h18, 3'b100,
          32'hFF00_0FF0);
    issue("nor",   4'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd6, 32'h1C, 3'b100, 32'hFFFF_FFFF);
    issue("sll",   4'd7, 32'd0, 32'd1, 32'h100, 1'b0, 1'b1, 5'd0, 5'd6, 32'h20, 3'b100, 32'h10);
    issue("srl",   4'd8, 32'd0, 32'h8000_0000, 32'h100, 1'b0, 1'b1, 5'd0, 5'd6, 32'h24, 3'b100,
          32'h0800_0000);
    issue("lui",   4'd9, 32'd0, 32'd0, 32'h1234, 1'b1, 1'b0, 5'd11, 5'd6, 32'h28, 3'b100,
          32'h1234_0000);
    issue("op12",  4'd12, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 5'd0, 5'd6, 32'h2C, 3'b100, 32'd0);
    issue("store", 4'd0, 32'h1000, 32'hCAFE, 32'd8, 1'b1, 1'b0, 5'd12, 5'd0, 32'h30, 3'b001,
          32'h1008);
    issue("load",  4'd0, 32'h2000, 32'd0, 32'd4, 1'b1, 1'b0, 5'd13, 5'd0, 32'h34, 3'b110, 32'h2004);

    // Bubble: controls clear, data holds.
    tick();
    chk("bubble_valid", {31'd0, ValidOut}, 32'd0);
    chk("bubble_hold", ResultOut, last_res);

    // Flush of a normal instruction: nothing is produced, data holds.
    drive(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd1, 32'd0, 3'b111);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, ValidOut}, 32'd0);
    chk("flush_ctl", {29'd0, RegWriteOut, MemReadOut, MemWriteOut}, 32'd0);
    chk("flush_hold", ResultOut, last_res);

`ifdef EX_MULT_EN
    // Multiply: 32 stall cycles, one result at edge T+32.
    drive(4'd10, 32'd1234, 32'd5678, 32'd0, 1'b0, 1'b1, 5'd0, 5'd8, 32'h40, 3'b100);
    push_exp(32'd7006652);
    #1;
    n = 0;
    while (stall_out === 1'b1 && n < 40) begin
      n++;
      tick();
      DatoLec1 = 32'hDEAD_BEEF;  // ID/EX contents must be ignored while multiplying
      #1;
    end
    chk("mul_stall_cycles", 32'(n), 32'd32);
    chk("mul_not_early", 32'(sb.size()), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("mul_done", 32'(sb.size()), 32'd0);
    chk("mul_valid", {31'd0, ValidOut}, 32'd1);
    tick();
    chk("mul_single", {31'd0, ValidOut}, 32'd0);

    // Flush while multiplying at cnt=10.
    drive(4'd10, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1, 5'd0, 5'd9, 32'h50, 3'b100);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("mulfl_stall_before", {31'd0, stall_out}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("mulfl_valid", {31'd0, ValidOut}, 32'd0);
    chk("mulfl_stall", {31'd0, stall_out}, 32'd0);
    repeat (3) tick();
    issue("add_after_flush", 4'd0, 32'd20, 32'd22, 32'd0, 1'b0, 1'b1, 5'd0, 5'd10, 32'h60, 3'b100,
          32'd42);
`else
    // No multiplier: code 10 is unsupported, result 0 in one cycle, no stall.
    drive(4'd10, 32'd1234, 32'd5678, 32'd0, 1'b0, 1'b1, 5'd0, 5'd8, 32'h40, 3'b100);
    #1;
    chk("mul_nostall", {31'd0, stall_out}, 32'd0);
    push_exp(32'd0);
    tick();
    in_valid = 1'b0;
    chk("mul_latency", 32'(sb.size()), 32'd0);
    issue("add_after_mul", 4'd0, 32'd20, 32'd22, 32'd0, 1'b0, 1'b1, 5'd0, 5'd10, 32'h60, 3'b100,
          32'd42);
`endif

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
